// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with a 2-bit saturating BHT, trained from EX resolution.
// Optional BP_STATS_EN adds branch/mispredict statistics counters and a same-cycle write-to-read bypass.
module branch_predictor #(
  parameter int         INDEX_W  = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] if_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_is_br_i,
  input  logic        ex_is_uncbr_i,
  input  logic        ex_taken_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic [31:0] ex_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_br_cnt_o,
  output logic [31:0] stat_mispred_cnt_o
`endif
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 32 - INDEX_W - 2;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  logic             r_jump   [ENTRIES];
  logic [1:0]       r_cnt    [ENTRIES];

  logic [INDEX_W-1:0] w_if_idx, w_ex_idx;
  logic [TAG_W-1:0]   w_if_tag, w_ex_tag;
  logic [31:0]        w_if_pc4, w_ex_pc4, w_act_next;
  logic               w_is_ctrl;

  assign w_if_idx   = if_pc_i[INDEX_W+1:2];
  assign w_if_tag   = if_pc_i[31:INDEX_W+2];
  assign w_ex_idx   = ex_pc_i[INDEX_W+1:2];
  assign w_ex_tag   = ex_pc_i[31:INDEX_W+2];
  assign w_if_pc4   = if_pc_i + 32'd4;
  assign w_ex_pc4   = ex_pc_i + 32'd4;
  assign w_act_next = ex_taken_i ? ex_target_i : w_ex_pc4;
  assign w_is_ctrl  = ex_is_br_i | ex_is_uncbr_i;

  // Current contents of the entry addressed by the EX instruction.
  logic             w_e_valid, w_e_jump;
  logic [TAG_W-1:0] w_e_tag;
  logic [31:0]      w_e_target;
  logic [1:0]       w_e_cnt;

  assign w_e_valid  = r_valid[w_ex_idx];
  assign w_e_tag    = r_tag[w_ex_idx];
  assign w_e_target = r_target[w_ex_idx];
  assign w_e_jump   = r_jump[w_ex_idx];
  assign w_e_cnt    = r_cnt[w_ex_idx];

  logic             w_upd_en;
  logic             w_nxt_valid, w_nxt_jump;
  logic [TAG_W-1:0] w_nxt_tag;
  logic [31:0]      w_nxt_target;
  logic [1:0]       w_nxt_cnt;

  // Whole-entry next value; fields not touched by the update keep their contents.
  always_comb begin
    w_upd_en     = 1'b0;
    w_nxt_valid  = w_e_valid;
    w_nxt_tag    = w_e_tag;
    w_nxt_target = w_e_target;
    w_nxt_jump   = w_e_jump;
    w_nxt_cnt    = w_e_cnt;
    if (ex_valid_i) begin
      if (ex_is_uncbr_i) begin
        w_upd_en     = 1'b1;
        w_nxt_valid  = 1'b1;
        w_nxt_tag    = w_ex_tag;
        w_nxt_target = ex_target_i;
        w_nxt_jump   = 1'b1;
        w_nxt_cnt    = 2'd3;
      end else if (ex_is_br_i) begin
        w_upd_en = 1'b1;
        if (ex_taken_i) begin
          w_nxt_cnt    = (w_e_cnt == 2'd3) ? 2'd3 : w_e_cnt + 2'd1;
          w_nxt_valid  = 1'b1;
          w_nxt_tag    = w_ex_tag;
          w_nxt_target = ex_target_i;
          w_nxt_jump   = 1'b0;
        end else begin
          w_nxt_cnt = (w_e_cnt == 2'd0) ? 2'd0 : w_e_cnt - 2'd1;
        end
      end else if (w_e_valid && (w_e_tag == w_ex_tag)) begin
        w_upd_en    = 1'b1;
        w_nxt_valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_jump[i]   <= 1'b0;
        r_cnt[i]    <= CNT_INIT;
      end
    end else if (w_upd_en) begin
      r_valid[w_ex_idx]  <= w_nxt_valid;
      r_tag[w_ex_idx]    <= w_nxt_tag;
      r_target[w_ex_idx] <= w_nxt_target;
      r_jump[w_ex_idx]   <= w_nxt_jump;
      r_cnt[w_ex_idx]    <= w_nxt_cnt;
    end
  end

  logic             w_lk_valid, w_lk_jump, w_hit;
  logic [TAG_W-1:0] w_lk_tag;
  logic [31:0]      w_lk_target;
  logic [1:0]       w_lk_cnt;

`ifdef BP_STATS_EN
  logic w_byp;
  assign w_byp       = w_upd_en && (w_ex_idx == w_if_idx);
  assign w_lk_valid  = w_byp ? w_nxt_valid  : r_valid[w_if_idx];
  assign w_lk_tag    = w_byp ? w_nxt_tag    : r_tag[w_if_idx];
  assign w_lk_target = w_byp ? w_nxt_target : r_target[w_if_idx];
  assign w_lk_jump   = w_byp ? w_nxt_jump   : r_jump[w_if_idx];
  assign w_lk_cnt    = w_byp ? w_nxt_cnt    : r_cnt[w_if_idx];
`else
  assign w_lk_valid  = r_valid[w_if_idx];
  assign w_lk_tag    = r_tag[w_if_idx];
  assign w_lk_target = r_target[w_if_idx];
  assign w_lk_jump   = r_jump[w_if_idx];
  assign w_lk_cnt    = r_cnt[w_if_idx];
`endif

  assign w_hit         = w_lk_valid && (w_lk_tag == w_if_tag);
  assign pred_taken_o  = rst_ni && w_hit && (w_lk_jump || w_lk_cnt[1]);
  assign pred_target_o = pred_taken_o ? w_lk_target : w_if_pc4;

  // A non-branch predicted taken can only have come from an aliased BTB hit.
  always_comb begin
    mispredict_o  = 1'b0;
    redirect_pc_o = w_ex_pc4;
    if (rst_ni && ex_valid_i) begin
      redirect_pc_o = w_act_next;
      if (w_is_ctrl)
        mispredict_o = (ex_pred_taken_i != ex_taken_i) ||
                       (ex_taken_i && (ex_pred_target_i != ex_target_i));
      else
        mispredict_o = ex_pred_taken_i;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_br, r_stat_mp;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (ex_valid_i && w_is_ctrl && (r_stat_br != 32'hFFFF_FFFF))
        r_stat_br <= r_stat_br + 32'd1;
      if (mispredict_o && (r_stat_mp != 32'hFFFF_FFFF))
        r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_br_cnt_o      = r_stat_br;
  assign stat_mispred_cnt_o = r_stat_mp;
`endif

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage dynamic branch predictor: a direct-mapped BTB plus a 2-bit saturating-counter BHT.
- Predicts `pc_sel` and target for the fetch PC in the same cycle.
- Consumes the EX-stage branch resolution (taken/target from the branch unit) to train its tables.
- Flags a misprediction and supplies the redirect PC to the fetch mux.

Parameters:
- INDEX_W, 6, table index width; entries = 2**INDEX_W; index = pc[INDEX_W+1:2].
- CNT_INIT, 2'b01, BHT counter reset value (weakly not-taken).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- if_pc_i  input  32  fetch PC.
- pred_taken_o  output  1  predicted taken for if_pc_i.
- pred_target_o  output  32  predicted target; if_pc_i+4 when not taken.
- ex_valid_i  input  1  EX holds a valid (non-bubble, non-flushed) instruction.
- ex_pc_i  input  32  PC of the EX instruction.
- ex_is_br_i  input  1  conditional branch.
- ex_is_uncbr_i  input  1  JAL/JALR.
- ex_taken_i  input  1  resolved taken (`pc_sel` from the branch unit).
- ex_target_i  input  32  resolved target address.
- ex_pred_taken_i  input  1  prediction carried down the pipe with the instruction.
- ex_pred_target_i  input  32  predicted target carried down the pipe.
- mispredict_o  output  1  redirect fetch and flush IF/ID.
- redirect_pc_o  output  32  correct next PC.

Behaviour:
- Storage per entry:
  - BTB: valid(1), tag(32-INDEX_W-2), target(32), jump(1).
  - BHT: cnt(2), untagged.
- Reset (async, rst_ni=0):
  - all valid=0, cnt=CNT_INIT, targets/tags/jump=0, stats counters=0.
  - Tables in flight are discarded; no update is lost or half-written after rst_ni deasserts.
- Lookup (combinational, 0-cycle):
  - hit = valid[idx] & tag[idx]==if_pc_i[31:INDEX_W+2].
  - pred_taken_o = hit & (jump[idx] | cnt[idx][1]).
  - pred_target_o = pred_taken_o ? target[idx] : if_pc_i+4 (32-bit wrap).
  - During reset: pred_taken_o=0, pred_target_o=if_pc_i+4.
- Resolution (combinational in the EX cycle):
  - act_next = ex_taken_i ? ex_target_i : ex_pc_i+4.
  - If ex_valid_i=0: mispredict_o=0, redirect_pc_o=ex_pc_i+4.
  - For a branch/jump: mispredict_o = ex_pred_taken_i!=ex_taken_i | (ex_taken_i & ex_pred_target_i!=ex_target_i).
  - For a non-branch: mispredict_o = ex_pred_taken_i (alias hit).
  - redirect_pc_o = act_next.
- Update (registered at the clock edge after the EX cycle, only when ex_valid_i=1):
  - Conditional branch, counter:
    - taken: cnt = min(cnt+1, 3).
    - not taken: cnt = max(cnt-1, 0).
  - Conditional branch, BTB:
    - taken: write valid=1, tag, target=ex_target_i, jump=0.
    - not taken: BTB unchanged.
  - Unconditional (ex_is_uncbr_i has priority over ex_is_br_i):
    - BTB write valid=1, jump=1, target=ex_target_i.
    - cnt forced to 3.
  - Non-branch with tag hit at ex_pc_i's index: clear valid of that entry; cnt unchanged.
  - Taken write to an entry holding a different tag: overwrite (no replacement policy).
- Simultaneous lookup and update to the same index:
  - Lookup returns the pre-update contents (no bypass unless the optional feature is enabled).
  - The update is visible from the next cycle.
- Counter saturation:
  - cnt=3 & taken stays 3.
  - cnt=0 & not-taken stays 0.
  - No wrap.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_br_cnt_o[31:0] and stat_mispred_cnt_o[31:0].
  - stat_br_cnt_o increments on each valid EX branch/jump.
  - stat_mispred_cnt_o increments on each cycle with mispredict_o=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
  - Adds a same-cycle write-to-read bypass: a lookup at the index being updated that cycle sees the new BTB/BHT values.
- Undefined: no counters, no extra ports, no bypass; prediction behaviour otherwise identical.

Test Plan:
- Reset, then lookup pc=0x100 -> pred_taken_o=0, pred_target_o=0x104; ex_valid_i=0 -> mispredict_o=0.
- BEQ at 0x200, target 0x240, taken, ex_pred_taken_i=0 -> mispredict_o=1, redirect_pc_o=0x240. Next cycle, lookup 0x200 -> cnt=2'b10, pred_taken_o=1, target 0x240.
- Same branch resolved not-taken 3 times from cnt=3 -> cnt steps 2, 1, 0. Lookup shows pred_taken_o=0 after the second update. Stays 0 after the fourth.
- JAL at 0x300 to 0x1000 -> next lookup of 0x300 gives pred_taken_o=1, target 0x1000. Aliasing non-branch at 0x300+(4<<INDEX_W), predicted taken via forced-matching tag -> mispredict_o=1, redirect 0x404 (pc+4 for 0x400 with INDEX_W=6); entry invalidated.
- Correctly predicted branch whose target differs (pred 0x500, actual 0x540) -> mispredict_o=1, redirect_pc_o=0x540, BTB target updated to 0x540.
- rst_ni asserted mid-update with BTB populated -> all outputs return to reset values immediately; lookups miss after release. With BP_STATS_EN, both stat counters read 0.
